pj_perf_counter_unit: RTL and testbench

Memory-mapped performance-counter responder sitting on the picoJava-II core's external data bus, next to the memory controller. Software enables and disables counting by writing 1 or 0 to the control word at the performance-counter address. It clears counters through a dedicated register and reads back cycle and per-event counts. Gated hardware event strobes from the core (cache, pipeline-hold and FPU activity) feed the per-event counters.

---
 rtl/pj_perf_counter_unit.sv | 129 ++++++++++++
 tb/tb_pj_perf_counter_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pj_perf_counter_unit.sv
// Memory-mapped performance-counter responder on the picoJava-II data bus.
// Counts enabled cycles and per-event strobes; reads/writes complete with a one-cycle ack.
module pj_perf_counter_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_FFF0,
  parameter int          NUM_EVENTS = 8,
  parameter int          CNT_W      = 32
) (
  input  logic                  pj_clk,
  input  logic                  pj_reset,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wdata,
  output logic                  bus_ack,
  output logic [31:0]           bus_rdata,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic                  cntr_on,
  output logic                  ovf_irq
);

  // Handshake: an access is taken when bus_req=1 with a claimed address while IDLE;
  // bus_ack is high for exactly the following cycle, bus_rdata valid only then.
  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  localparam logic [29:0]      BASE_W   = BASE_ADDR[31:2];
  localparam logic [29:0]      NUM_REGS = 30'(4 + NUM_EVENTS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_next;
  logic             on, inv, ovf;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] event_cnt [NUM_EVENTS];

  logic [29:0] off_w;
  logic        claimed, access, wr_ctrl, wr_status, wr_clear, wrap_any;
  logic [31:0] rd_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus_addr[1:0];
  assign off_w     = bus_addr[31:2] - BASE_W;
  assign claimed   = (bus_addr[31:2] >= BASE_W) && (off_w < NUM_REGS);
  assign access    = (state == ST_IDLE) && bus_req && claimed;
  assign wr_ctrl   = access && bus_we && (off_w == 30'd0);
  assign wr_status = access && bus_we && (off_w == 30'd1);
  assign wr_clear  = access && bus_we && (off_w == 30'd3);

  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus_ack    = 1'b0;
    case (state)
      ST_IDLE: if (access) state_next = ST_RESP;
      ST_RESP: begin
        bus_ack    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A wrap is any counter at all-ones that increments on this edge.
  always_comb begin
    wrap_any = 1'b0;
    if (on) begin
      if (&cycle_cnt) wrap_any = 1'b1;
      for (int i = 0; i < NUM_EVENTS; i++)
        if (event_in[i] && (&event_cnt[i])) wrap_any = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    if (off_w == 30'd0)      rd_val = {31'b0, on};
    else if (off_w == 30'd1) rd_val = {29'b0, ovf, inv, on};
    else if (off_w == 30'd2) rd_val = 32'(cycle_cnt);
    else begin
      for (int i = 0; i < NUM_EVENTS; i++)
        if (off_w == 30'(i + 4)) rd_val = 32'(event_cnt[i]);
    end
  end

  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset) begin
      cycle_cnt <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) event_cnt[i] <= '0;
    end else if (wr_clear) begin
      cycle_cnt <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) event_cnt[i] <= '0;
    end else if (on) begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      for (int i = 0; i < NUM_EVENTS; i++)
        if (event_in[i]) event_cnt[i] <= event_cnt[i] + CNT_ONE;
    end
  end

  // The ovf set is written last so it wins over a same-edge W1C.
  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset) begin
      on  <= 1'b0;
      inv <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        if (bus_wdata == 32'd1)      on  <= 1'b1;
        else if (bus_wdata == 32'd0) on  <= 1'b0;
        else                         inv <= 1'b1;
      end
      if (wr_status) begin
        if (bus_wdata[1]) inv <= 1'b0;
        if (bus_wdata[2]) ovf <= 1'b0;
      end
      if (wrap_any && !wr_clear) ovf <= 1'b1;
    end
  end

  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset)                bus_rdata <= '0;
    else if (access && !bus_we)  bus_rdata <= rd_val;
    else                         bus_rdata <= '0;
  end

  assign cntr_on = on;
  assign ovf_irq = ovf;

endmodule

// File: tb/tb_pj_perf_counter_unit.sv
// Scoreboard bench for pj_perf_counter_unit: a register-level reference model pushes
// expected responses when an access is taken; a negedge monitor pops and compares.
module tb_pj_perf_counter_unit;

  localparam int          NE   = 8;
  localparam int          CW   = 8;
  localparam int          MOD  = 1 << CW;
  localparam logic [31:0] BASE = 32'h0000_FFF0;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          pj_reset = 1'b1;
  logic          bus_req = 1'b0;
  logic          bus_we = 1'b0;
  logic [31:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic          bus_ack;
  logic [31:0]   bus_rdata;
  logic [NE-1:0] event_in = '0;
  logic          cntr_on;
  logic          ovf_irq;

  always #5 clk = ~clk;

  pj_perf_counter_unit #(.BASE_ADDR(BASE), .NUM_EVENTS(NE), .CNT_W(CW)) dut (
    .pj_clk(clk), .pj_reset(pj_reset),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .event_in(event_in), .cntr_on(cntr_on), .ovf_irq(ovf_irq)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];   // {is_read, expected rdata}

  // ---------------- reference model ----------------
  bit m_on = 0, m_inv = 0, m_ovf = 0, m_resp = 0;
  int m_cycle = 0;
  int m_ev[NE];
  bit            ev_rand = 0;
  logic [NE-1:0] ev_fixed = '0;

  task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_claimed(input logic [31:0] a);
    longint aa = longint'(a) - (longint'(a) % 4);
    return (aa >= longint'(BASE)) && (aa < longint'(BASE) + 16 + 4 * NE);
  endfunction

  function automatic int reg_index(input logic [31:0] a);
    longint aa = longint'(a) - (longint'(a) % 4);
    return int'((aa - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0:       return {31'b0, m_on};
      1:       return {29'b0, m_ovf, m_inv, m_on};
      2:       return 32'(m_cycle);
      3:       return 32'd0;
      default: return 32'(m_ev[idx - 4]);
    endcase
  endfunction

  always @(posedge clk or posedge pj_reset) begin
    bit take, wrap, wr;
    int idx;
    if (pj_reset) begin
      m_on = 0; m_inv = 0; m_ovf = 0; m_resp = 0; m_cycle = 0;
      foreach (m_ev[i]) m_ev[i] = 0;
      exp_q.delete();
    end else begin
      take = !m_resp && bus_req && is_claimed(bus_addr);
      idx  = take ? reg_index(bus_addr) : -1;
      wr   = take && bus_we;
      m_resp = take;
      if (take) exp_q.push_back({!bus_we, bus_we ? 32'd0 : model_read(idx)});
      wrap = 0;
      if (m_on) begin
        m_cycle = (m_cycle + 1) % MOD;
        if (m_cycle == 0) wrap = 1;
        for (int i = 0; i < NE; i++)
          if (event_in[i]) begin
            m_ev[i] = (m_ev[i] + 1) % MOD;
            if (m_ev[i] == 0) wrap = 1;
          end
      end
      if (wr && idx == 3) begin
        m_cycle = 0;
        foreach (m_ev[i]) m_ev[i] = 0;
        wrap = 0;
      end
      if (wr && idx == 1) begin
        if (bus_wdata[1]) m_inv = 0;
        if (bus_wdata[2]) m_ovf = 0;
      end
      if (wr && idx == 0) begin
        if (bus_wdata == 32'd1)      m_on = 1;
        else if (bus_wdata == 32'd0) m_on = 0;
        else                         m_inv = 1;
      end
      if (wrap) m_ovf = 1;
    end
  end

  // Event strobes change just after the rising edge so they are stable for the next one.
  always @(posedge clk) begin
    #2;
    event_in = ev_rand ? NE'($urandom) : ev_fixed;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (!pj_reset) begin
      do_check("ack_timing", {31'b0, bus_ack}, {31'b0, m_resp});
      if (bus_ack) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: got ack with empty queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) do_check("rdata", bus_rdata, e[31:0]);
        end
      end
      do_check("cntr_on", {31'b0, cntr_on}, {31'b0, m_on});
      do_check("ovf_irq", {31'b0, ovf_irq}, {31'b0, m_ovf});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bit got = 0;
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (bus_ack) got = 1;
    end
    bus_req = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ack_timeout: got no ack expected ack for addr 0x%08h", addr);
    end
  endtask

  task automatic rd(input int idx);
    bus_access(1'b0, BASE + 32'(4 * idx), 32'd0);
  endtask

  task automatic wr(input int idx, input logic [31:0] data);
    bus_access(1'b1, BASE + 32'(4 * idx), data);
  endtask

  task automatic unclaimed_access(input logic we, input logic [31:0] addr);
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = $urandom;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      do_check("unclaimed_no_ack", {31'b0, bus_ack}, 32'd0);
    end
    bus_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    pj_reset = 1'b0;

    // Reset state reads
    rd(0); rd(1); rd(2); rd(4);

    // Enable, 10 cycles with event 2 pulsed 4 times, disable
    wr(0, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ev_fixed = (i % 3 == 0) ? NE'(4) : '0;
    end
    @(negedge clk);
    ev_fixed = '0;
    wr(0, 32'd0);
    rd(2); rd(6); rd(5);

    // Invalid CTRL value and W1C of inv
    wr(0, 32'd5);
    rd(0); rd(1);
    wr(1, 32'd2);
    rd(1);

    // Wrap of EVENT[0] and CYCLE, ovf_irq, W1C of ovf
    wr(3, 32'd0);
    ev_fixed = NE'(1);
    wr(0, 32'd1);
    repeat (260) @(negedge clk);
    wr(0, 32'd0);
    ev_fixed = '0;
    rd(4); rd(2); rd(1);
    wr(1, 32'd4);
    rd(1);

    // CLEAR while counting random events
    ev_rand = 1;
    wr(0, 32'd1);
    repeat (20) @(negedge clk);
    wr(3, 32'hDEAD_BEEF);
    rd(2);
    for (int i = 0; i < NE; i++) rd(4 + i);

    // Unclaimed window edges
    unclaimed_access(1'b0, BASE - 32'd4);
    unclaimed_access(1'b1, BASE + 32'(16 + 4 * NE));
    unclaimed_access(1'b0, BASE + 32'(16 + 4 * NE + 3));

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      int op = $urandom_range(0, 9);
      int idx = $urandom_range(0, 4 + NE - 1);
      logic [31:0] lo = 32'($urandom_range(0, 3));
      case (op)
        0, 1, 2, 3, 4: bus_access(1'b0, BASE + 32'(4 * idx) + lo, 32'd0);
        5: wr(0, ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 1) | ($urandom_range(0, 2) != 0)));
        6: wr(1, 32'($urandom_range(0, 7)));
        7: wr(3, $urandom);
        8: bus_access(1'b1, BASE + 32'(4 * ($urandom_range(0, 1) == 0 ? 2 : 4 + $urandom_range(0, NE - 1))) + lo, $urandom);
        default: begin
          if ($urandom_range(0, 1) == 0)
            unclaimed_access(1'($urandom), BASE - 32'(4 * $urandom_range(1, 4)) + lo);
          else
            unclaimed_access(1'($urandom), BASE + 32'(16 + 4 * NE + 4 * $urandom_range(0, 4)) + lo);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset asserted while the response is on the bus
    wr(0, 32'd1);
    repeat (5) @(negedge clk);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = BASE + 32'd8;
    @(posedge clk);
    #2;
    pj_reset = 1'b1;
    bus_req  = 1'b0;
    #1;
    do_check("reset_ack", {31'b0, bus_ack}, 32'd0);
    do_check("reset_rdata", bus_rdata, 32'd0);
    do_check("reset_cntr_on", {31'b0, cntr_on}, 32'd0);
    do_check("reset_ovf_irq", {31'b0, ovf_irq}, 32'd0);
    @(negedge clk);
    pj_reset = 1'b0;
    rd(0); rd(1); rd(2); rd(4);

    repeat (5) @(negedge clk);
    do_check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
